// File: rtl/register_read_stage_pkg.sv
// Shared core types for the register-read stage: physical register sizing,
// the scheduler issue packet and the execute packet derived from it.
package register_read_stage_pkg;

  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_idx_t;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MUL    = 2'd1,
    FU_LSU    = 2'd2,
    FU_BRANCH = 2'd3
  } fu_type_e;

  typedef struct packed {
    logic [31:0] pc;
    preg_idx_t   src1_preg;
    preg_idx_t   src2_preg;
    preg_idx_t   dst_preg;
    logic [31:0] imm_val;
    logic        instr_valid;
    logic [5:0]  rob_idx;
    fu_type_e    fu_type;
    logic [3:0]  alu_op;
  } sched_pkt_t;

  typedef struct packed {
    sched_pkt_t  sched;
    logic [31:0] src1_val;
    logic [31:0] src2_val;
  } exec_pkt_t;

  // Forwarded data is newer than the register file copy, so it always wins.
  function automatic logic [31:0] pick_operand(input logic        fwrd_hit,
                                               input logic [31:0] fwrd_val,
                                               input logic [31:0] rf_val);
    return fwrd_hit ? fwrd_val : rf_val;
  endfunction

endpackage

// File: rtl/register_read_stage_if.sv
// Interfaces around the register-read stage: scheduler in, register file and
// forwarding lookups, execute out. The stage uses the modport named per file.
interface scheduler_reg_read_if;
  import register_read_stage_pkg::*;

  // fire_valid qualifies sched_pkt for exactly one cycle; there is no ready,
  // so the receiver must take every fired packet.
  logic       fire_valid;
  sched_pkt_t sched_pkt;

  modport master (output fire_valid, output sched_pkt);
  modport slave  (input  fire_valid, input  sched_pkt);
endinterface

interface reg_read_phys_reg_file_if;
  import register_read_stage_pkg::*;

  preg_idx_t   src1_reg;
  preg_idx_t   src2_reg;
  logic [31:0] src1_val;
  logic [31:0] src2_val;

  modport master (output src1_reg, output src2_reg, input  src1_val, input  src2_val);
  modport slave  (input  src1_reg, input  src2_reg, output src1_val, output src2_val);
endinterface

interface fwrd_reg_read_if;
  import register_read_stage_pkg::*;

  preg_idx_t   src1_reg;
  preg_idx_t   src2_reg;
  logic        src1_fwrd_hit;
  logic        src2_fwrd_hit;
  logic [31:0] src1_val;
  logic [31:0] src2_val;

  modport master (output src1_reg, output src2_reg,
                  input  src1_fwrd_hit, input src2_fwrd_hit,
                  input  src1_val, input src2_val);
  modport slave  (input  src1_reg, input  src2_reg,
                  output src1_fwrd_hit, output src2_fwrd_hit,
                  output src1_val, output src2_val);
endinterface

interface reg_read_execute_if;
  import register_read_stage_pkg::*;

  logic      fire_valid;
  exec_pkt_t exec_pkt;

  modport master (output fire_valid, output exec_pkt);
  modport slave  (input  fire_valid, input  exec_pkt);
endinterface

// File: rtl/register_read_stage_operand_select.sv
// One source operand: forwarding network value on a hit, else register file.
module operand_select
  import register_read_stage_pkg::*;
(
  input  logic        fwrd_hit,
  input  logic [31:0] fwrd_val,
  input  logic [31:0] rf_val,
  output logic [31:0] operand
);

  always_comb begin
    operand = pick_operand(fwrd_hit, fwrd_val, rf_val);
  end

endmodule

// File: rtl/register_read_stage.sv
// Register-read stage: combinational source lookup, operand select, and a
// one-cycle pipeline register into the execute packet.
module register_read_stage
  import register_read_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  scheduler_reg_read_if.slave      sched_if,
  reg_read_phys_reg_file_if.master reg_file_if,
  fwrd_reg_read_if.master          fwrd_if,
  reg_read_execute_if.master       exec_if
);

  logic [31:0] operand_1;
  logic [31:0] operand_2;

  // Lookups follow sched_pkt regardless of fire_valid or reset.
  always_comb begin
    reg_file_if.src1_reg = sched_if.sched_pkt.src1_preg;
    reg_file_if.src2_reg = sched_if.sched_pkt.src2_preg;
    fwrd_if.src1_reg     = sched_if.sched_pkt.src1_preg;
    fwrd_if.src2_reg     = sched_if.sched_pkt.src2_preg;
  end

  operand_select u_src1_sel (
    .fwrd_hit (fwrd_if.src1_fwrd_hit),
    .fwrd_val (fwrd_if.src1_val),
    .rf_val   (reg_file_if.src1_val),
    .operand  (operand_1)
  );

  operand_select u_src2_sel (
    .fwrd_hit (fwrd_if.src2_fwrd_hit),
    .fwrd_val (fwrd_if.src2_val),
    .rf_val   (reg_file_if.src2_val),
    .operand  (operand_2)
  );

  // Non-fired cycles load an all-zero bubble so stale data never lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_if.fire_valid <= 1'b0;
      exec_if.exec_pkt   <= '0;
    end else if (sched_if.fire_valid) begin
      exec_if.fire_valid        <= 1'b1;
      exec_if.exec_pkt.sched    <= sched_if.sched_pkt;
      exec_if.exec_pkt.src1_val <= operand_1;
      exec_if.exec_pkt.src2_val <= operand_2;
    end else begin
      exec_if.fire_valid <= 1'b0;
      exec_if.exec_pkt   <= '0;
    end
  end

endmodule

// File: tb/tb_register_read_stage.sv
// Directed bench for register_read_stage with hand-computed expectations.
module tb_register_read_stage;
  import register_read_stage_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scheduler_reg_read_if     sched_if ();
  reg_read_phys_reg_file_if reg_file_if ();
  fwrd_reg_read_if          fwrd_if ();
  reg_read_execute_if       exec_if ();

  register_read_stage dut (
    .clk         (clk),
    .rst         (rst),
    .sched_if    (sched_if),
    .reg_file_if (reg_file_if),
    .fwrd_if     (fwrd_if),
    .exec_if     (exec_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_sched(input logic fire, input logic [31:0] pc,
                             input preg_idx_t s1, input preg_idx_t s2, input preg_idx_t d,
                             input logic [31:0] imm, input logic iv);
    sched_pkt_t p;
    p             = '0;
    p.pc          = pc;
    p.src1_preg   = s1;
    p.src2_preg   = s2;
    p.dst_preg    = d;
    p.imm_val     = imm;
    p.instr_valid = iv;
    sched_if.fire_valid = fire;
    sched_if.sched_pkt  = p;
  endtask

  task automatic drive_ops(input logic h1, input logic [31:0] f1,
                           input logic h2, input logic [31:0] f2,
                           input logic [31:0] r1, input logic [31:0] r2);
    fwrd_if.src1_fwrd_hit = h1;
    fwrd_if.src1_val      = f1;
    fwrd_if.src2_fwrd_hit = h2;
    fwrd_if.src2_val      = f2;
    reg_file_if.src1_val  = r1;
    reg_file_if.src2_val  = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sched_pkt_t pt;
    exec_pkt_t  exp_pkt;
    logic [31:0] exp_pc;
    logic [31:0] exp_v;

    rst = 1'b1;
    drive_sched(1'b0, 32'h0, 6'd5, 6'd10, 6'd0, 32'h0, 1'b0);
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    check_eq("reset_fire_valid", exec_if.fire_valid, 1'b0);
    check_eq("reset_exec_pkt", exec_if.exec_pkt, '0);
    check_eq("reset_idx_follow", reg_file_if.src2_reg, 6'd10);
    rst = 1'b0;

    // register file read
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    drive_sched(1'b1, 32'h1000, 6'd5, 6'd10, 6'd15, 32'h42, 1'b1);
    #1;
    check_eq("rf_idx1", reg_file_if.src1_reg, 6'd5);
    check_eq("rf_idx2", reg_file_if.src2_reg, 6'd10);
    check_eq("fw_idx1", fwrd_if.src1_reg, 6'd5);
    check_eq("fw_idx2", fwrd_if.src2_reg, 6'd10);
    step();
    check_eq("rf_fire_valid", exec_if.fire_valid, 1'b1);
    check_eq("rf_src1", exec_if.exec_pkt.src1_val, 32'hAAAA_AAAA);
    check_eq("rf_src2", exec_if.exec_pkt.src2_val, 32'hBBBB_BBBB);
    check_eq("rf_dst", exec_if.exec_pkt.sched.dst_preg, 6'd15);
    check_eq("rf_imm", exec_if.exec_pkt.sched.imm_val, 32'h42);
    check_eq("rf_pc", exec_if.exec_pkt.sched.pc, 32'h1000);

    // forwarding, each source independently then both
    drive_ops(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h1111_1111, 32'h2222_2222);
    step();
    check_eq("fw1_src1", exec_if.exec_pkt.src1_val, 32'hDEAD_BEEF);
    check_eq("fw1_src2", exec_if.exec_pkt.src2_val, 32'h2222_2222);
    drive_ops(1'b0, 32'h0, 1'b1, 32'hCAFE_BABE, 32'h3333_3333, 32'h4444_4444);
    step();
    check_eq("fw2_src1", exec_if.exec_pkt.src1_val, 32'h3333_3333);
    check_eq("fw2_src2", exec_if.exec_pkt.src2_val, 32'hCAFE_BABE);
    drive_ops(1'b1, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 32'h5555_5555, 32'h6666_6666);
    step();
    check_eq("fwb_src1", exec_if.exec_pkt.src1_val, 32'h1234_5678);
    check_eq("fwb_src2", exec_if.exec_pkt.src2_val, 32'h9ABC_DEF0);

    // bubbles, with and without forwarding hits present
    drive_sched(1'b0, 32'h1000, 6'd5, 6'd10, 6'd15, 32'h42, 1'b1);
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'h7777_7777, 32'h7777_7777);
    step();
    check_eq("bubble_valid", exec_if.fire_valid, 1'b0);
    check_eq("bubble_pkt", exec_if.exec_pkt, '0);
    drive_ops(1'b1, 32'hFFFF_0001, 1'b1, 32'hFFFF_0002, 32'h7777_7777, 32'h7777_7777);
    step();
    check_eq("hit_nofire_valid", exec_if.fire_valid, 1'b0);
    check_eq("hit_nofire_pkt", exec_if.exec_pkt, '0);

    // back-to-back fires through the expected queue
    drive_sched(1'b1, 32'h2000, 6'd1, 6'd2, 6'd3, 32'h0, 1'b1);
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'hAAAA_0000, 32'h0);
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'hAAAA_0000);
    step();
    exp_pc = exp_q.pop_front();
    exp_v  = exp_q.pop_front();
    check_eq("b2b0_valid", exec_if.fire_valid, 1'b1);
    check_eq("b2b0_pc", exec_if.exec_pkt.sched.pc, exp_pc);
    check_eq("b2b0_src1", exec_if.exec_pkt.src1_val, exp_v);
    drive_sched(1'b1, 32'h2004, 6'd1, 6'd2, 6'd3, 32'h0, 1'b1);
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'hCCCC_0000, 32'h0);
    exp_q.push_back(32'h2004);
    exp_q.push_back(32'hCCCC_0000);
    step();
    exp_pc = exp_q.pop_front();
    exp_v  = exp_q.pop_front();
    check_eq("b2b1_valid", exec_if.fire_valid, 1'b1);
    check_eq("b2b1_pc", exec_if.exec_pkt.sched.pc, exp_pc);
    check_eq("b2b1_src1", exec_if.exec_pkt.src1_val, exp_v);

    // full pass-through including control fields
    drive_sched(1'b1, 32'hFEED_FACE, 6'd25, 6'd26, 6'd27, 32'hDEAD_BEEF, 1'b1);
    pt         = sched_if.sched_pkt;
    pt.rob_idx = 6'h2A;
    pt.fu_type = FU_LSU;
    pt.alu_op  = 4'h9;
    sched_if.sched_pkt = pt;
    drive_ops(1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 32'h0101_0101, 32'h0202_0202);
    exp_pkt          = '0;
    exp_pkt.sched.pc          = 32'hFEED_FACE;
    exp_pkt.sched.src1_preg   = 6'd25;
    exp_pkt.sched.src2_preg   = 6'd26;
    exp_pkt.sched.dst_preg    = 6'd27;
    exp_pkt.sched.imm_val     = 32'hDEAD_BEEF;
    exp_pkt.sched.instr_valid = 1'b1;
    exp_pkt.sched.rob_idx     = 6'h2A;
    exp_pkt.sched.fu_type     = FU_LSU;
    exp_pkt.sched.alu_op      = 4'h9;
    exp_pkt.src1_val          = 32'h0101_0101;
    exp_pkt.src2_val          = 32'h0BAD_F00D;
    step();
    check_eq("pass_pkt", exec_if.exec_pkt, exp_pkt);

    // index 0 is an ordinary register
    drive_sched(1'b1, 32'h3000, 6'd0, 6'd0, 6'd1, 32'h0, 1'b1);
    drive_ops(1'b0, 32'h0, 1'b0, 32'h0, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
    #1;
    check_eq("zero_idx1", reg_file_if.src1_reg, 6'd0);
    check_eq("zero_idx2", fwrd_if.src2_reg, 6'd0);
    step();
    check_eq("zero_src1", exec_if.exec_pkt.src1_val, 32'h5A5A_5A5A);
    check_eq("zero_src2", exec_if.exec_pkt.src2_val, 32'hA5A5_A5A5);

    // reset during a fire drops the instruction
    rst = 1'b1;
    drive_sched(1'b1, 32'h4000, 6'd7, 6'd8, 6'd9, 32'h1, 1'b1);
    step();
    check_eq("rst_fire_valid", exec_if.fire_valid, 1'b0);
    check_eq("rst_fire_pkt", exec_if.exec_pkt, '0);
    rst = 1'b0;
    step();
    check_eq("post_rst_pc", exec_if.exec_pkt.sched.pc, 32'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
